masked_rf_ctrl: RTL and testbench
=================================

Name: masked_rf_ctrl

Overview:
- Command sequencer for the 16x64-bit masked share register file (`register_file`) in the masked crypto unit.
- Accepts one command at a time over a valid/ready interface: LOAD, MASK, ARK or READ.
- Collects fresh randomness from the RNG, drives the register-file strobes and address/data buses, and returns read data over a response handshake.
- Register-file write enables are mutually exclusive by construction; data buses are zeroed when not in use, so no share leaks onto idle wires.

Parameters:
- NUM_REGS, 16, register-file depth; address width is clog2(NUM_REGS) = 4.
- DATA_W, 64, word width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  controller idle and able to accept a command
- cmd_op_i  in  2  00 LOAD, 01 MASK, 10 ARK, 11 READ
- cmd_dst_i  in  4  destination/base register
- cmd_src_i  in  4  source register (MASK share source, ARK key base)
- cmd_data0_i / cmd_data1_i  in  64 each  LOAD payload
- rnd_valid_i  in  1  RNG word valid
- rnd_data_i  in  64  RNG word
- rnd_ready_o  out  1  RNG word consumed
- rf_addr_o  out  4  register-file addr_i
- rf_in0_o / rf_in1_o / rf_in2_o  out  64 each  register-file input0/1/2
- rf_write_en_o, rf_random_o, rf_ark_o, rf_read_en_o  out  1 each  register-file strobes
- rf_rdata_i  in  64  register-file output_o (combinational read)
- rsp_valid_o  out  1  read response valid
- rsp_ready_i  in  1  read response accepted
- rsp_data_o  out  128  {word dst+1, word dst}
- done_o  out  1  one-cycle pulse when a command completes
- err_o  out  1  one-cycle pulse when a command is rejected
- round_cnt_o  out  4  ARK operations since last LOAD, saturating at 15

Behaviour:
- Reset (asynchronous, rst_ni=0):
  - FSM goes to IDLE; all registers clear.
  - Outputs: cmd_ready_o=1 (it is IDLE-derived); every other output, including round_cnt_o and rsp_data_o, is 0.
- States: IDLE, LOAD, RND0, RND1, MASK, ARK, RD0, RD1, RSP.
- IDLE:
  - cmd_ready_o=1; a command is accepted on cmd_valid_i & cmd_ready_o.
  - op, dst, src and data are latched on acceptance.
  - Range check, all in the same cycle:
    - LOAD: dst<=14.
    - MASK: dst<=12 and src<=14.
    - ARK: dst<=12 and src<=12.
    - READ: dst<=14.
  - A failing command is consumed, err_o pulses in the next cycle, and the FSM stays in IDLE with no register-file access.
  - A passing command moves to LOAD, RND0, ARK or RD0 respectively.
- LOAD (1 cycle):
  - rf_write_en_o=1, rf_addr_o=dst, rf_in0_o=data0, rf_in1_o=data1.
  - done_o pulses; round_cnt_o clears to 0; next state IDLE.
- RND0 / RND1:
  - rnd_ready_o=1; a word is taken on rnd_valid_i & rnd_ready_o into r0, then r1.
  - The FSM stalls indefinitely with no timeout.
  - RND0 moves to RND1, and RND1 to MASK, only on a handshake.
- MASK (1 cycle):
  - rf_write_en_o=1, rf_random_o=1, rf_addr_o=dst.
  - rf_in0_o={60'b0,src}, rf_in1_o=r0, rf_in2_o=r1.
  - done_o pulses; r0 and r1 clear to 0 in the same edge; next state IDLE.
- ARK (1 cycle):
  - rf_write_en_o=1, rf_ark_o=1, rf_in0_o={60'b0,dst}, rf_in1_o={60'b0,src}, rf_addr_o=0.
  - round_cnt_o increments, saturating at 15; done_o pulses; next state IDLE.
- RD0 / RD1:
  - RD0: rf_read_en_o=1, rf_addr_o=dst; rf_rdata_i captured into rsp_data_o[63:0].
  - RD1: rf_read_en_o=1, rf_addr_o=dst+1; rf_rdata_i captured into rsp_data_o[127:64].
  - RD1 moves to RSP.
- RSP:
  - rsp_valid_o=1, rsp_data_o held stable until rsp_ready_i.
  - On the handshake: done_o pulses, rsp_data_o clears to 0, next state IDLE.
- Exclusivity and bus hygiene:
  - At most one of rf_write_en_o / rf_read_en_o is high per cycle.
  - rf_random_o and rf_ark_o are never both high.
  - rf_in*_o are 0 in every state other than LOAD, MASK and ARK.
- Pipelining: cmd_ready_o is low in every non-IDLE state, so there is no command overlap. A new command is accepted no earlier than the cycle after the FSM returns to IDLE.
- Latency, acceptance to done_o:
  - LOAD and ARK: 1 cycle.
  - MASK: 3 cycles plus RNG stall.
  - READ: 3 cycles plus response stall.
- Reset mid-operation:
  - Partially collected randomness and any captured read data are discarded.
  - No register-file write is in flight, because every write is a single cycle.
- rnd_valid_i outside RND0/RND1 is ignored.

Decomposition:
- Package masked_rf_pkg holds:
  - op_e enum (LOAD, MASK, ARK, READ);
  - state_e enum;
  - NUM_REGS, DATA_W and RF_ADDR_W;
  - per-op address limits.
- Sub-module masked_rf_rnd_buf:
  - two-word RNG collector with a ready/valid front end;
  - clear input; full output.

Test Plan:
- Reset, then LOAD dst=4, data0=0x1111, data1=0x2222 -> exactly 1 cycle with rf_write_en_o=1, rf_addr_o=4, in0=0x1111, in1=0x2222; done_o next cycle; round_cnt_o=0.
- MASK dst=8, src=4 with RNG words 0xAAAA, 0x5555, rnd_valid_i delayed 5 cycles -> single MASK cycle with rf_random_o=1, in0=4, in1=0xAAAA, in2=0x5555; following READ dst=10 returns {0x5555, 0xAAAA}.
- Three ARKs dst=8, src=12 -> three single-cycle ark strobes with in0=8, in1=12; round_cnt_o=3. Then 14 more -> round_cnt_o saturates at 15; LOAD -> 0.
- READ dst=0 after LOAD {0xBEEF, 0xCAFE} with rsp_ready_i held low for 4 cycles -> rsp_valid_o steady and rsp_data_o={0xCAFE, 0xBEEF} until the handshake; cmd_ready_o=0 throughout.
- Illegal MASK dst=13 and ARK src=14 -> err_o pulse each; no rf strobe; rnd_ready_o never asserted.
- Assert rst_ni low in RND1 after one RNG word -> all outputs 0 immediately; following MASK consumes two fresh words.

Source files
------------

// File: rtl/masked_rf_ctrl_pkg.sv
// Shared types, sizes and command legality rules for the masked register-file controller.
package masked_rf_pkg;

    localparam int unsigned NUM_REGS  = 16;
    localparam int unsigned DATA_W    = 64;
    localparam int unsigned RF_ADDR_W = $clog2(NUM_REGS);
    localparam int unsigned RSP_W     = 2 * DATA_W;
    localparam int unsigned CNT_W     = 4;

    typedef logic [RF_ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0]    word_t;

    typedef enum logic [1:0] {
        OpLoad = 2'b00,
        OpMask = 2'b01,
        OpArk  = 2'b10,
        OpRead = 2'b11
    } op_e;

    typedef enum logic [3:0] {
        StIdle,
        StLoad,
        StRnd0,
        StRnd1,
        StMask,
        StArk,
        StRd0,
        StRd1,
        StRsp
    } state_e;

    // Highest legal register index per operand; multi-word ops need headroom above the base.
    localparam addr_t LOAD_DST_MAX = 4'd14;
    localparam addr_t MASK_DST_MAX = 4'd12;
    localparam addr_t MASK_SRC_MAX = 4'd14;
    localparam addr_t ARK_DST_MAX  = 4'd12;
    localparam addr_t ARK_SRC_MAX  = 4'd12;
    localparam addr_t READ_DST_MAX = 4'd14;

    localparam logic [CNT_W-1:0] ROUND_MAX = 4'd15;

    function automatic logic cmd_legal(op_e op, addr_t dst, addr_t src);
        logic ok;
        unique case (op)
            OpLoad: ok = (dst <= LOAD_DST_MAX);
            OpMask: ok = (dst <= MASK_DST_MAX) && (src <= MASK_SRC_MAX);
            OpArk:  ok = (dst <= ARK_DST_MAX) && (src <= ARK_SRC_MAX);
            OpRead: ok = (dst <= READ_DST_MAX);
        endcase
        return ok;
    endfunction

    // Register indices are passed to the register file zero-extended on a data bus.
    function automatic word_t zext_addr(addr_t a);
        return {{(DATA_W - RF_ADDR_W){1'b0}}, a};
    endfunction

endpackage

// File: rtl/masked_rf_ctrl_if.sv
// Bundle of command, RNG, register-file and response signals around the controller.
interface masked_rf_ctrl_if;
    import masked_rf_pkg::*;

    logic             cmd_valid_i;
    logic             cmd_ready_o;
    logic [1:0]       cmd_op_i;
    addr_t            cmd_dst_i;
    addr_t            cmd_src_i;
    word_t            cmd_data0_i;
    word_t            cmd_data1_i;

    logic             rnd_valid_i;
    word_t            rnd_data_i;
    logic             rnd_ready_o;

    addr_t            rf_addr_o;
    word_t            rf_in0_o;
    word_t            rf_in1_o;
    word_t            rf_in2_o;
    logic             rf_write_en_o;
    logic             rf_random_o;
    logic             rf_ark_o;
    logic             rf_read_en_o;
    word_t            rf_rdata_i;

    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic [RSP_W-1:0] rsp_data_o;

    logic             done_o;
    logic             err_o;
    logic [CNT_W-1:0] round_cnt_o;

    // Controller side.
    modport master (
        input  cmd_valid_i, cmd_op_i, cmd_dst_i, cmd_src_i, cmd_data0_i, cmd_data1_i,
        input  rnd_valid_i, rnd_data_i, rf_rdata_i, rsp_ready_i,
        output cmd_ready_o, rnd_ready_o,
        output rf_addr_o, rf_in0_o, rf_in1_o, rf_in2_o,
        output rf_write_en_o, rf_random_o, rf_ark_o, rf_read_en_o,
        output rsp_valid_o, rsp_data_o, done_o, err_o, round_cnt_o
    );

    // Environment side: command source, RNG, register file and response sink.
    modport slave (
        output cmd_valid_i, cmd_op_i, cmd_dst_i, cmd_src_i, cmd_data0_i, cmd_data1_i,
        output rnd_valid_i, rnd_data_i, rf_rdata_i, rsp_ready_i,
        input  cmd_ready_o, rnd_ready_o,
        input  rf_addr_o, rf_in0_o, rf_in1_o, rf_in2_o,
        input  rf_write_en_o, rf_random_o, rf_ark_o, rf_read_en_o,
        input  rsp_valid_o, rsp_data_o, done_o, err_o, round_cnt_o
    );

endinterface

// File: rtl/masked_rf_rnd_buf.sv
// Two-word randomness collector: fills r0 then r1 from a ready/valid RNG stream.
module masked_rf_rnd_buf
    import masked_rf_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  collect,
    input  logic  clear,
    input  logic  rnd_valid,
    input  word_t rnd_data,
    output logic  rnd_ready,
    output word_t r0,
    output word_t r1,
    output logic  full
);

    logic [1:0] cnt_q;
    word_t      r0_q;
    word_t      r1_q;
    logic       take;

    assign full      = (cnt_q == 2'd2);
    assign rnd_ready = collect && !full;
    assign take      = rnd_valid && rnd_ready;
    assign r0        = r0_q;
    assign r1        = r1_q;

    // Word store; clear wipes both shares of randomness once they have been used.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 2'd0;
            r0_q  <= '0;
            r1_q  <= '0;
        end else if (clear) begin
            cnt_q <= 2'd0;
            r0_q  <= '0;
            r1_q  <= '0;
        end else if (take) begin
            if (cnt_q == 2'd0) begin
                r0_q <= rnd_data;
            end else begin
                r1_q <= rnd_data;
            end
            cnt_q <= cnt_q + 2'd1;
        end
    end

endmodule

// File: rtl/masked_rf_ctrl.sv
// Command sequencer for the masked share register file: LOAD, MASK, ARK and READ.
module masked_rf_ctrl
    import masked_rf_pkg::*;
(
    input logic              clk_i,
    input logic              rst_ni,
    masked_rf_ctrl_if.master bus
);

    state_e           state_q, state_d;
    addr_t            dst_q;
    addr_t            src_q;
    word_t            data0_q;
    word_t            data1_q;
    logic [RSP_W-1:0] rsp_data_q, rsp_data_d;
    logic [CNT_W-1:0] round_cnt_q, round_cnt_d;
    logic             err_q, err_d;

    logic             cmd_hs;
    logic             cmd_ok;
    logic             rnd_collect;
    logic             rnd_clear;
    logic             rnd_ready;
    logic             rnd_full;
    logic             rnd_hs;
    word_t            r0;
    word_t            r1;

    assign cmd_hs      = bus.cmd_valid_i && (state_q == StIdle);
    assign cmd_ok      = cmd_legal(op_e'(bus.cmd_op_i), bus.cmd_dst_i, bus.cmd_src_i);
    assign rnd_collect = (state_q == StRnd0) || (state_q == StRnd1);
    assign rnd_clear   = (state_q == StMask);
    assign rnd_hs      = bus.rnd_valid_i && rnd_ready;

    assign bus.rnd_ready_o = rnd_ready;
    assign bus.rsp_data_o  = rsp_data_q;
    assign bus.round_cnt_o = round_cnt_q;
    assign bus.err_o       = err_q;

    masked_rf_rnd_buf u_rnd_buf (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .collect   (rnd_collect),
        .clear     (rnd_clear),
        .rnd_valid (bus.rnd_valid_i),
        .rnd_data  (bus.rnd_data_i),
        .rnd_ready (rnd_ready),
        .r0        (r0),
        .r1        (r1),
        .full      (rnd_full)
    );

    // State, response, counter and error registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            rsp_data_q  <= '0;
            round_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_data_q  <= rsp_data_d;
            round_cnt_q <= round_cnt_d;
            err_q       <= err_d;
        end
    end

    // Command operands are captured on every accepted command.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dst_q   <= '0;
            src_q   <= '0;
            data0_q <= '0;
            data1_q <= '0;
        end else if (cmd_hs) begin
            dst_q   <= bus.cmd_dst_i;
            src_q   <= bus.cmd_src_i;
            data0_q <= bus.cmd_data0_i;
            data1_q <= bus.cmd_data1_i;
        end
    end

    // Next-state and strobe decode; every data bus defaults to zero so idle wires carry no share.
    always_comb begin
        state_d           = state_q;
        rsp_data_d        = rsp_data_q;
        round_cnt_d       = round_cnt_q;
        err_d             = 1'b0;
        bus.cmd_ready_o   = 1'b0;
        bus.rf_addr_o     = '0;
        bus.rf_in0_o      = '0;
        bus.rf_in1_o      = '0;
        bus.rf_in2_o      = '0;
        bus.rf_write_en_o = 1'b0;
        bus.rf_random_o   = 1'b0;
        bus.rf_ark_o      = 1'b0;
        bus.rf_read_en_o  = 1'b0;
        bus.rsp_valid_o   = 1'b0;
        bus.done_o        = 1'b0;

        unique case (state_q)
            StIdle: begin
                bus.cmd_ready_o = 1'b1;
                if (cmd_hs) begin
                    if (!cmd_ok) begin
                        err_d = 1'b1;
                    end else begin
                        unique case (op_e'(bus.cmd_op_i))
                            OpLoad: state_d = StLoad;
                            OpMask: state_d = StRnd0;
                            OpArk:  state_d = StArk;
                            OpRead: state_d = StRd0;
                        endcase
                    end
                end
            end
            StLoad: begin
                bus.rf_write_en_o = 1'b1;
                bus.rf_addr_o     = dst_q;
                bus.rf_in0_o      = data0_q;
                bus.rf_in1_o      = data1_q;
                bus.done_o        = 1'b1;
                round_cnt_d       = '0;
                state_d           = StIdle;
            end
            StRnd0: begin
                if (rnd_hs) begin
                    state_d = StRnd1;
                end
            end
            StRnd1: begin
                // full only rises after the second handshake; kept as a safety exit.
                if (rnd_hs || rnd_full) begin
                    state_d = StMask;
                end
            end
            StMask: begin
                bus.rf_write_en_o = 1'b1;
                bus.rf_random_o   = 1'b1;
                bus.rf_addr_o     = dst_q;
                bus.rf_in0_o      = zext_addr(src_q);
                bus.rf_in1_o      = r0;
                bus.rf_in2_o      = r1;
                bus.done_o        = 1'b1;
                state_d           = StIdle;
            end
            StArk: begin
                bus.rf_write_en_o = 1'b1;
                bus.rf_ark_o      = 1'b1;
                bus.rf_in0_o      = zext_addr(dst_q);
                bus.rf_in1_o      = zext_addr(src_q);
                bus.done_o        = 1'b1;
                if (round_cnt_q != ROUND_MAX) begin
                    round_cnt_d = round_cnt_q + 4'd1;
                end
                state_d = StIdle;
            end
            StRd0: begin
                bus.rf_read_en_o        = 1'b1;
                bus.rf_addr_o           = dst_q;
                rsp_data_d[DATA_W-1:0]  = bus.rf_rdata_i;
                state_d                 = StRd1;
            end
            StRd1: begin
                bus.rf_read_en_o           = 1'b1;
                bus.rf_addr_o              = dst_q + addr_t'(1);
                rsp_data_d[RSP_W-1:DATA_W] = bus.rf_rdata_i;
                state_d                    = StRsp;
            end
            StRsp: begin
                bus.rsp_valid_o = 1'b1;
                if (bus.rsp_ready_i) begin
                    bus.done_o = 1'b1;
                    rsp_data_d = '0;
                    state_d    = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_masked_rf_ctrl.sv
// Directed bench for masked_rf_ctrl: vector table for single-cycle commands plus
// hand sequences for MASK, READ and mid-operation reset.
module tb_masked_rf_ctrl;

    logic clk;
    logic rst_ni;
    int   n_vec;
    int   n_fail;

    masked_rf_ctrl_if bus ();

    masked_rf_ctrl dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file stand-in: LOAD writes dst/dst+1, MASK writes r0/r1 at dst+2/dst+3.
    logic [63:0] mem [16];
    always @(posedge clk) begin
        if (bus.rf_write_en_o && !bus.rf_random_o && !bus.rf_ark_o) begin
            mem[bus.rf_addr_o]        <= bus.rf_in0_o;
            mem[bus.rf_addr_o + 4'd1] <= bus.rf_in1_o;
        end else if (bus.rf_write_en_o && bus.rf_random_o) begin
            mem[bus.rf_addr_o + 4'd2] <= bus.rf_in1_o;
            mem[bus.rf_addr_o + 4'd3] <= bus.rf_in2_o;
        end
    end
    assign bus.rf_rdata_i = mem[bus.rf_addr_o];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Exclusivity and bus hygiene every cycle out of reset.
    always @(negedge clk) begin
        if (rst_ni) begin
            n_vec++;
            if ((bus.rf_write_en_o && bus.rf_read_en_o) || (bus.rf_random_o && bus.rf_ark_o) ||
                (!bus.rf_write_en_o &&
                 ((bus.rf_in0_o | bus.rf_in1_o | bus.rf_in2_o) != 64'd0))) begin
                n_fail++;
                $display("FAIL hygiene: we=%b re=%b rnd=%b ark=%b in0=%0h in1=%0h in2=%0h",
                         bus.rf_write_en_o, bus.rf_read_en_o, bus.rf_random_o, bus.rf_ark_o,
                         bus.rf_in0_o, bus.rf_in1_o, bus.rf_in2_o);
            end
        end
    end

    // Waits for cmd_ready, presents the command for one accepting edge, returns at edge+1.
    task automatic issue(input logic [1:0] op, input logic [3:0] dst, input logic [3:0] src,
                         input logic [63:0] d0, input logic [63:0] d1);
        int guard;
        guard = 0;
        while (!bus.cmd_ready_o && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.cmd_ready_o) begin
            check("issue_timeout", 0, 1);
            return;
        end
        bus.cmd_op_i    = op;
        bus.cmd_dst_i   = dst;
        bus.cmd_src_i   = src;
        bus.cmd_data0_i = d0;
        bus.cmd_data1_i = d1;
        bus.cmd_valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_data0_i = '0;
        bus.cmd_data1_i = '0;
    endtask

    task automatic do_read(input logic [3:0] dst, input logic [127:0] exp, input int stall);
        issue(2'b11, dst, 4'd0, 64'd0, 64'd0);
        @(negedge clk);
        check("rd0_read_en", bus.rf_read_en_o, 1);
        check("rd0_addr", bus.rf_addr_o, dst);
        @(negedge clk);
        check("rd1_addr", bus.rf_addr_o, dst + 4'd1);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("rsp_valid_stall", bus.rsp_valid_o, 1);
            check("rsp_data_stall", bus.rsp_data_o, exp);
            check("cmd_ready_stall", bus.cmd_ready_o, 0);
            check("done_stall", bus.done_o, 0);
        end
        @(posedge clk);
        #1 bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        check("rsp_data_hs", bus.rsp_data_o, exp);
        check("rsp_done", bus.done_o, 1);
        @(posedge clk);
        #1 bus.rsp_ready_i = 1'b0;
        @(negedge clk);
        check("rsp_valid_after", bus.rsp_valid_o, 0);
        check("rsp_data_cleared", bus.rsp_data_o, 0);
        check("idle_ready", bus.cmd_ready_o, 1);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  dst;
        logic [3:0]  src;
        logic [63:0] d0;
        logic [63:0] d1;
        logic        err;
        logic        ark;
        logic [3:0]  addr;
        logic [63:0] in0;
        logic [63:0] in1;
        logic [3:0]  rnd;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic [1:0] op, logic [3:0] dst, logic [3:0] src,
                                logic [63:0] d0, logic [63:0] d1, logic err, logic ark,
                                logic [3:0] addr, logic [63:0] in0, logic [63:0] in1,
                                logic [3:0] rnd);
        vec_t v;
        v.op = op; v.dst = dst; v.src = src; v.d0 = d0; v.d1 = d1;
        v.err = err; v.ark = ark; v.addr = addr; v.in0 = in0; v.in1 = in1; v.rnd = rnd;
        return v;
    endfunction

    initial begin
        n_vec  = 0;
        n_fail = 0;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_op_i    = '0;
        bus.cmd_dst_i   = '0;
        bus.cmd_src_i   = '0;
        bus.cmd_data0_i = '0;
        bus.cmd_data1_i = '0;
        bus.rnd_valid_i = 1'b0;
        bus.rnd_data_i  = '0;
        bus.rsp_ready_i = 1'b0;

        // op dst src d0 d1 | err ark addr in0 in1 round
        vt.push_back(mk(2'b00, 4'd14, 4'd0, 64'h14, 64'h15, 0, 0, 4'd14, 64'h14, 64'h15, 0));
        vt.push_back(mk(2'b00, 4'd4, 4'd0, 64'h1111, 64'h2222, 0, 0, 4'd4, 64'h1111, 64'h2222, 0));
        vt.push_back(mk(2'b10, 4'd8, 4'd12, 0, 0, 0, 1, 4'd0, 64'd8, 64'd12, 1));
        vt.push_back(mk(2'b10, 4'd8, 4'd12, 0, 0, 0, 1, 4'd0, 64'd8, 64'd12, 2));
        vt.push_back(mk(2'b10, 4'd8, 4'd12, 0, 0, 0, 1, 4'd0, 64'd8, 64'd12, 3));
        vt.push_back(mk(2'b01, 4'd13, 4'd4, 0, 0, 1, 0, 4'd0, 0, 0, 3));
        vt.push_back(mk(2'b10, 4'd8, 4'd14, 0, 0, 1, 0, 4'd0, 0, 0, 3));
        vt.push_back(mk(2'b00, 4'd15, 4'd0, 64'h5, 64'h6, 1, 0, 4'd0, 0, 0, 3));
        vt.push_back(mk(2'b11, 4'd15, 4'd0, 0, 0, 1, 0, 4'd0, 0, 0, 3));
        vt.push_back(mk(2'b10, 4'd13, 4'd0, 0, 0, 1, 0, 4'd0, 0, 0, 3));
        vt.push_back(mk(2'b01, 4'd12, 4'd15, 0, 0, 1, 0, 4'd0, 0, 0, 3));
        vt.push_back(mk(2'b10, 4'd12, 4'd12, 0, 0, 0, 1, 4'd0, 64'd12, 64'd12, 4));
        for (int i = 0; i < 14; i++) begin
            vt.push_back(mk(2'b10, 4'd8, 4'd12, 0, 0, 0, 1, 4'd0, 64'd8, 64'd12,
                            (i < 10) ? 4'(5 + i) : 4'd15));
        end
        vt.push_back(mk(2'b00, 4'd0, 4'd0, 64'hBEEF, 64'hCAFE, 0, 0, 4'd0, 64'hBEEF, 64'hCAFE, 0));

        // Reset state.
        rst_ni = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", bus.cmd_ready_o, 1);
        check("rst_strobes", {bus.rf_write_en_o, bus.rf_read_en_o, bus.rf_random_o,
                              bus.rf_ark_o, bus.rnd_ready_o, bus.rsp_valid_o,
                              bus.done_o, bus.err_o}, 0);
        check("rst_round", bus.round_cnt_o, 0);
        check("rst_rsp_data", bus.rsp_data_o, 0);
        rst_ni = 1'b1;
        @(negedge clk);

        foreach (vt[k]) begin
            issue(vt[k].op, vt[k].dst, vt[k].src, vt[k].d0, vt[k].d1);
            @(negedge clk);
            check($sformatf("v%0d_err", k), bus.err_o, vt[k].err);
            check($sformatf("v%0d_we", k), bus.rf_write_en_o, !vt[k].err);
            check($sformatf("v%0d_ark", k), bus.rf_ark_o, vt[k].ark);
            check($sformatf("v%0d_random", k), bus.rf_random_o, 0);
            check($sformatf("v%0d_rnd_ready", k), bus.rnd_ready_o, 0);
            check($sformatf("v%0d_addr", k), bus.rf_addr_o, vt[k].addr);
            check($sformatf("v%0d_in0", k), bus.rf_in0_o, vt[k].in0);
            check($sformatf("v%0d_in1", k), bus.rf_in1_o, vt[k].in1);
            check($sformatf("v%0d_done", k), bus.done_o, !vt[k].err);
            @(negedge clk);
            check($sformatf("v%0d_round", k), bus.round_cnt_o, vt[k].rnd);
            check($sformatf("v%0d_err_pulse", k), bus.err_o, 0);
        end

        // READ with a four-cycle response stall.
        do_read(4'd0, {64'hCAFE, 64'hBEEF}, 4);

        // MASK with the RNG five cycles late.
        issue(2'b01, 4'd8, 4'd4, 0, 0);
        repeat (5) begin
            @(negedge clk);
            check("rnd_wait_ready", bus.rnd_ready_o, 1);
            check("rnd_wait_we", bus.rf_write_en_o, 0);
        end
        @(posedge clk);
        #1 bus.rnd_valid_i = 1'b1;
        bus.rnd_data_i = 64'hAAAA;
        @(posedge clk);
        #1 bus.rnd_data_i = 64'h5555;
        @(posedge clk);
        #1 bus.rnd_valid_i = 1'b0;
        bus.rnd_data_i = '0;
        @(negedge clk);
        check("mask_we_rnd", {bus.rf_write_en_o, bus.rf_random_o, bus.rf_ark_o}, 3'b110);
        check("mask_addr", bus.rf_addr_o, 8);
        check("mask_in0", bus.rf_in0_o, 4);
        check("mask_in1", bus.rf_in1_o, 64'hAAAA);
        check("mask_in2", bus.rf_in2_o, 64'h5555);
        check("mask_done", bus.done_o, 1);
        @(negedge clk);
        check("mask_single", bus.rf_write_en_o, 0);
        do_read(4'd10, {64'h5555, 64'hAAAA}, 0);

        // One ARK so the reset below has a counter to clear.
        issue(2'b10, 4'd0, 4'd1, 0, 0);
        @(negedge clk);
        @(negedge clk);
        check("ark_round_1", bus.round_cnt_o, 1);

        // Reset in RND1 after one word, then a MASK must use two fresh words.
        issue(2'b01, 4'd8, 4'd4, 0, 0);
        bus.rnd_valid_i = 1'b1;
        bus.rnd_data_i  = 64'h1234;
        @(posedge clk);
        #1 bus.rnd_valid_i = 1'b0;
        @(negedge clk);
        check("rnd1_ready", bus.rnd_ready_o, 1);
        #2 rst_ni = 1'b0;
        #1;
        check("mid_rst_ready", bus.cmd_ready_o, 1);
        check("mid_rst_strobes", {bus.rnd_ready_o, bus.rf_write_en_o, bus.done_o}, 0);
        check("mid_rst_round", bus.round_cnt_o, 0);
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        issue(2'b01, 4'd4, 4'd2, 0, 0);
        bus.rnd_valid_i = 1'b1;
        bus.rnd_data_i  = 64'h77;
        @(posedge clk);
        #1 bus.rnd_data_i = 64'h88;
        @(posedge clk);
        #1 bus.rnd_valid_i = 1'b0;
        @(negedge clk);
        check("fresh_mask_we", bus.rf_random_o, 1);
        check("fresh_mask_in0", bus.rf_in0_o, 2);
        check("fresh_mask_in1", bus.rf_in1_o, 64'h77);
        check("fresh_mask_in2", bus.rf_in2_o, 64'h88);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
